sbox_pipe_scheduler: RTL and testbench
======================================

SBOX_PIPE_SCHEDULER -- requirements
Module: sbox_pipe_scheduler

Interface
REQ-001 Parameter: NIBBLES, 16, number of 4-bit cells per state processed in one job.
REQ-002 Parameter: LATENCY, 5, clock cycles from S-box input to S-box output; matches the GHPC d1 pipelined S-box.
REQ-003 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports: start  in  1  job request; busy  out  1  job in progress; done  out  1  one-cycle completion pulse.
REQ-006 Ports: state_in_s0, state_in_s1  in  4*NIBBLES  input state shares; state_out_s0, state_out_s1  out  4*NIBBLES  result shares.
REQ-007 Ports: rnd_data  in  4  fresh randomness; rnd_valid  in  1  rnd_data usable; rnd_ready  out  1  rnd_data consumed this cycle.
REQ-008 Ports: sbox_x_s0, sbox_x_s1  out  4  S-box input shares; sbox_fresh  out  4  S-box Fresh bus; sbox_y_s0, sbox_y_s1  in  4  S-box output shares.
REQ-009 Port: rnd_err  out  1  sticky flag: randomness missing during a job.

Function
REQ-010 FSM states SHALL be IDLE, ISSUE, DRAIN, FIN; reset state IDLE.
REQ-011 IDLE: start=1 at a rising edge SHALL latch both state_in shares into internal input registers, clear rnd_err, and enter ISSUE.
REQ-012 ISSUE SHALL last exactly NIBBLES cycles; in issue cycle i (i=0..NIBBLES-1), sbox_x_s0/s1 SHALL carry nibble i (bits 4i+3:4i) of the latched shares.
REQ-013 DRAIN SHALL last exactly LATENCY cycles, with sbox_x_s0/s1 driven to 0.
REQ-014 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-015 busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE and FIN.
REQ-016 A LATENCY-deep valid/index shift register SHALL track each issued nibble; when an entry exits, sbox_y_s0/s1 SHALL be written to nibble <index> of state_out_s0/s1.
REQ-017 Output nibble i SHALL be captured exactly LATENCY cycles after issue cycle i; bubbles (valid=0) SHALL NOT write state_out.
REQ-018 done SHALL first rise in the cycle NIBBLES+LATENCY+1 cycles after the start-sampling edge (22 at defaults).
REQ-019 state_out_s0/s1 SHALL hold their values from done until the next accepted start; they SHALL NOT be updated nibble-by-nibble outside a job.
REQ-020 rnd_ready SHALL equal busy; sbox_fresh SHALL equal rnd_data while busy, else 0.
REQ-021 rnd_valid=0 in any busy cycle SHALL set rnd_err; rnd_err SHALL persist until the next accepted start or reset; the job SHALL NOT stall.
REQ-022 start while busy or in FIN SHALL be ignored, with no effect on the running job.
REQ-023 Randomness words SHALL never be reused: no internal storage of rnd_data.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, rnd_ready=0, rnd_err=0, sbox_x_s0/s1=0, sbox_fresh=0, valid shift register all 0, state_out_s0/s1=0.
REQ-025 Reset asserted mid-job SHALL abort the job; S-box outputs still in flight after release SHALL be discarded (valid cleared).
REQ-026 The first start after reset release SHALL behave as REQ-011.

Verification
REQ-027 Reset: rst_n low mid-ISSUE -> all outputs 0 within the same cycle; after release no state_out write occurs without start.
REQ-028 Single job: state_in_s0=0x0123456789ABCDEF, state_in_s1=0, rnd_valid=1 -> done at cycle 22, state_out_s0^state_out_s1=0xC6901A2B385D4E7F, rnd_err=0.
REQ-029 Masked job: same plaintext with random nonzero state_in_s1, random rnd_data each cycle -> recombined output 0xC6901A2B385D4E7F.
REQ-030 Randomness gap: rnd_valid=0 for one cycle in DRAIN -> rnd_err=1 at done, timing unchanged; next start clears rnd_err.
REQ-031 Start collisions: start held high continuously -> back-to-back jobs, one done per 23 cycles; start pulsed during ISSUE ignored.
REQ-032 Bubble check: in IDLE with sbox_y driven to 0xF -> state_out unchanged.

Source files
------------

// File: rtl/sbox_pipe_scheduler_if.sv
// ---------------------------------------------------------------------------
// sbox_pipe_scheduler_if
// Bundles the job handshake, state buses, randomness handshake and the
// external pipelined S-box connection of sbox_pipe_scheduler.
//
//   start          job request                   (master -> slave)
//   busy           job in progress               (slave -> master)
//   done           one-cycle completion pulse    (slave -> master)
//   state_in_s0/1  input state shares            (master -> slave)
//   state_out_s0/1 result state shares           (slave -> master)
//   rnd_data       fresh randomness nibble       (master -> slave)
//   rnd_valid      rnd_data usable               (master -> slave)
//   rnd_ready      rnd_data consumed this cycle  (slave -> master)
//   rnd_err        sticky missing-randomness flag(slave -> master)
//   sbox_x_s0/1    S-box input shares            (slave -> master)
//   sbox_fresh     S-box Fresh bus               (slave -> master)
//   sbox_y_s0/1    S-box output shares           (master -> slave)
// ---------------------------------------------------------------------------
interface sbox_pipe_scheduler_if #(
  parameter int NIBBLES = 16
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [4*NIBBLES-1:0] state_in_s0;
  logic [4*NIBBLES-1:0] state_in_s1;
  logic [4*NIBBLES-1:0] state_out_s0;
  logic [4*NIBBLES-1:0] state_out_s1;
  logic [3:0]           rnd_data;
  logic                 rnd_valid;
  logic                 rnd_ready;
  logic                 rnd_err;
  logic [3:0]           sbox_x_s0;
  logic [3:0]           sbox_x_s1;
  logic [3:0]           sbox_fresh;
  logic [3:0]           sbox_y_s0;
  logic [3:0]           sbox_y_s1;

  modport master (
    output start, state_in_s0, state_in_s1, rnd_data, rnd_valid,
           sbox_y_s0, sbox_y_s1,
    input  busy, done, state_out_s0, state_out_s1, rnd_ready, rnd_err,
           sbox_x_s0, sbox_x_s1, sbox_fresh
  );

  modport slave (
    input  start, state_in_s0, state_in_s1, rnd_data, rnd_valid,
           sbox_y_s0, sbox_y_s1,
    output busy, done, state_out_s0, state_out_s1, rnd_ready, rnd_err,
           sbox_x_s0, sbox_x_s1, sbox_fresh
  );
endinterface

// File: rtl/sbox_pipe_scheduler.sv
// ---------------------------------------------------------------------------
// sbox_pipe_scheduler
// Streams the NIBBLES 4-bit cells of a two-share state, one per cycle,
// through an external LATENCY-deep masked S-box and reassembles the S-box
// results into a two-share output state.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sbox_pipe_scheduler_if.slave (job handshake, state shares,
//          randomness handshake, S-box connection)
//
// Job timeline (edge E0 samples start in IDLE):
//   ISSUE : NIBBLES cycles, cycle i drives nibble i to the S-box
//   DRAIN : LATENCY cycles, S-box inputs forced to zero
//   FIN   : one cycle with done=1, then IDLE
// ---------------------------------------------------------------------------
module sbox_pipe_scheduler #(
  parameter int NIBBLES = 16,
  parameter int LATENCY = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sbox_pipe_scheduler_if.slave bus
);

  localparam int IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int MAXC = (NIBBLES > LATENCY) ? NIBBLES : LATENCY;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int SW   = 4 * NIBBLES;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [SW-1:0]   r_sh0;
  logic [SW-1:0]   r_sh1;
  logic [SW-1:0]   r_out0;
  logic [SW-1:0]   r_out1;
  logic [LATENCY-1:0] r_vld;
  logic [IW-1:0]   r_idx [LATENCY];

  logic            w_issue;
  logic [IW-1:0]   w_issueIdx;

  assign w_issue    = (r_state == ISSUE);
  assign w_issueIdx = r_cnt[IW-1:0];

  // The latched input shares live in shift registers: the S-box input is
  // always the low nibble, and zeros shift in from the top, so after the
  // last issue cycle the S-box inputs are zero without any extra muxing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_sh0   <= '0;
      r_sh1   <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_busy && !bus.rnd_valid) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sh0   <= bus.state_in_s0;
            r_sh1   <= bus.state_in_s1;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_sh0 <= {4'b0000, r_sh0[SW-1:4]};
          r_sh1 <= {4'b0000, r_sh1[SW-1:4]};
          if (r_cnt == CW'(NIBBLES - 1)) begin
            r_cnt   <= '0;
            r_state <= DRAIN;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (r_cnt == CW'(LATENCY - 1)) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Each issued nibble index travels alongside the S-box pipeline; the
  // entry leaving the last stage lines up with that nibble's S-box result.
  // Reset clears the valid bits so results still in flight are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_idx[k] <= '0;
      end
      r_out0 <= '0;
      r_out1 <= '0;
    end else begin
      r_vld    <= {r_vld[LATENCY-2:0], w_issue};
      r_idx[0] <= w_issueIdx;
      for (int k = 1; k < LATENCY; k++) begin
        r_idx[k] <= r_idx[k-1];
      end
      if (r_vld[LATENCY-1]) begin
        r_out0[{r_idx[LATENCY-1], 2'b00} +: 4] <= bus.sbox_y_s0;
        r_out1[{r_idx[LATENCY-1], 2'b00} +: 4] <= bus.sbox_y_s1;
      end
    end
  end

  // Randomness is passed straight through, never stored.
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.rnd_ready    = r_busy;
  assign bus.rnd_err      = r_err;
  assign bus.sbox_x_s0    = r_sh0[3:0];
  assign bus.sbox_x_s1    = r_sh1[3:0];
  assign bus.sbox_fresh   = r_busy ? bus.rnd_data : 4'b0000;
  assign bus.state_out_s0 = r_out0;
  assign bus.state_out_s1 = r_out1;

endmodule

// File: tb/tb_sbox_pipe_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sbox_pipe_scheduler
// Directed bench for sbox_pipe_scheduler. A behavioural 5-stage masked
// SKINNY-64 S-box model sits on the S-box bus: its output in cycle t is
// S(x_s0 ^ x_s1) ^ fresh and fresh, taken from the inputs of cycle t-5.
// Cycle c below means the cycle that follows the c-th rising edge after
// the edge that accepted start (c = 0 is the first issue cycle).
// ---------------------------------------------------------------------------
module tb_sbox_pipe_scheduler;

  localparam int NIB = 16;
  localparam int LAT = 5;
  localparam logic [63:0] PLAIN = 64'h0123456789ABCDEF;
  localparam logic [63:0] CIPH  = 64'hC6901A2B385D4E7F;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic forceY = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [3:0] ym0 [LAT];
  logic [3:0] ym1 [LAT];

  sbox_pipe_scheduler_if #(.NIBBLES(NIB)) bus ();

  sbox_pipe_scheduler #(.NIBBLES(NIB), .LATENCY(LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] skinny(input logic [3:0] v);
    case (v)
      4'h0: return 4'hC;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
      4'h4: return 4'h1;  4'h5: return 4'hA;  4'h6: return 4'h2;  4'h7: return 4'hB;
      4'h8: return 4'h3;  4'h9: return 4'h8;  4'hA: return 4'h5;  4'hB: return 4'hD;
      4'hC: return 4'h4;  4'hD: return 4'hE;  4'hE: return 4'h7;  default: return 4'hF;
    endcase
  endfunction

  // Masked S-box model: share 1 carries the fresh nibble, share 0 the
  // S-box result masked with it.
  always @(posedge clk) begin
    ym0[0] <= skinny(bus.sbox_x_s0 ^ bus.sbox_x_s1) ^ bus.sbox_fresh;
    ym1[0] <= bus.sbox_fresh;
    for (int k = 1; k < LAT; k++) begin
      ym0[k] <= ym0[k-1];
      ym1[k] <= ym1[k-1];
    end
  end

  assign bus.sbox_y_s0 = forceY ? 4'hF : ym0[LAT-1];
  assign bus.sbox_y_s1 = forceY ? 4'hF : ym1[LAT-1];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("[TB] %s miscompared", tag);
    end
  endtask

  // Runs one job from the start request to three cycles past done,
  // tracking sequencing errors cycle by cycle against the fixed timeline.
  task automatic applyStimulus(
    input  logic [63:0] s0,
    input  logic [63:0] s1,
    input  bit          randFresh,
    input  int          gapAt,
    input  int          pulseAt,
    output int          firstDone,
    output int          doneCnt,
    output int          seqErr,
    output logic        errAtDone,
    output logic        errAtStart
  );
    logic [63:0] pl;
    logic [3:0]  expX;
    logic        expBusy;
    pl = s0 ^ s1;
    @(negedge clk);
    bus.state_in_s0 = s0;
    bus.state_in_s1 = s1;
    bus.start       = 1'b1;
    bus.rnd_valid   = 1'b1;
    bus.rnd_data    = randFresh ? 4'($urandom) : 4'h0;
    firstDone  = -1;
    doneCnt    = 0;
    seqErr     = 0;
    errAtDone  = 1'b0;
    errAtStart = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      expBusy = (c < 21);
      expX    = (c < 16) ? pl[4*c +: 4] : 4'h0;
      if (c == 0) errAtStart = bus.rnd_err;
      if (c == 21) errAtDone = bus.rnd_err;
      if (bus.done === 1'b1) begin
        doneCnt++;
        if (firstDone < 0) firstDone = c;
      end
      if (bus.busy !== expBusy) seqErr++;
      if (bus.rnd_ready !== expBusy) seqErr++;
      if (bus.sbox_fresh !== (expBusy ? bus.rnd_data : 4'h0)) seqErr++;
      if ((bus.sbox_x_s0 ^ bus.sbox_x_s1) !== expX) seqErr++;
      if (c >= 16 && (bus.sbox_x_s0 !== 4'h0 || bus.sbox_x_s1 !== 4'h0)) seqErr++;
      bus.rnd_valid = (c != gapAt);
      if (randFresh) bus.rnd_data = 4'($urandom);
      bus.start = (c == pulseAt);
    end
  endtask

  initial begin
    int          fd, dc, se, d1, d2, cnt, writes;
    logic        ead, eas;
    logic [63:0] mask;
    bit          seen;

    bus.start       = 1'b0;
    bus.state_in_s0 = '0;
    bus.state_in_s1 = '0;
    bus.rnd_data    = 4'h0;
    bus.rnd_valid   = 1'b1;

    // Reset values
    #12;
    checkOutput("reset_busy",  {63'd0, bus.busy}, 64'd0);
    checkOutput("reset_done",  {63'd0, bus.done}, 64'd0);
    checkOutput("reset_err",   {63'd0, bus.rnd_err}, 64'd0);
    checkOutput("reset_out0",  bus.state_out_s0, 64'd0);
    checkOutput("reset_out1",  bus.state_out_s1, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unmasked job with zero fresh: both shares are exactly known
    applyStimulus(PLAIN, 64'd0, 1'b0, -1, -1, fd, dc, se, ead, eas);
    checkOutput("job1_out0", bus.state_out_s0, CIPH);
    checkOutput("job1_out1", bus.state_out_s1, 64'd0);
    checkOutput("job1_done_cycle", 64'(fd), 64'd21);
    checkOutput("job1_done_count", 64'(dc), 64'd1);
    checkOutput("job1_sequence", 64'(se), 64'd0);
    checkOutput("job1_err", {63'd0, ead}, 64'd0);

    // Bubbles must not write while idle
    forceY = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("bubble_out0", bus.state_out_s0, CIPH);
    checkOutput("bubble_out1", bus.state_out_s1, 64'd0);
    forceY = 1'b0;

    // Masked job with random fresh every cycle
    mask = {$urandom, $urandom} | 64'h1;
    applyStimulus(PLAIN ^ mask, mask, 1'b1, -1, -1, fd, dc, se, ead, eas);
    checkOutput("job2_recomb", bus.state_out_s0 ^ bus.state_out_s1, CIPH);
    checkOutput("job2_done_cycle", 64'(fd), 64'd21);
    checkOutput("job2_sequence", 64'(se), 64'd0);
    checkOutput("job2_err", {63'd0, ead}, 64'd0);

    // One-cycle randomness gap in DRAIN
    mask = {$urandom, $urandom} | 64'h1;
    applyStimulus(PLAIN ^ mask, mask, 1'b1, 18, -1, fd, dc, se, ead, eas);
    checkOutput("gap_err_at_done", {63'd0, ead}, 64'd1);
    checkOutput("gap_done_cycle", 64'(fd), 64'd21);
    checkOutput("gap_recomb", bus.state_out_s0 ^ bus.state_out_s1, CIPH);
    checkOutput("gap_err_sticky", {63'd0, bus.rnd_err}, 64'd1);

    // Next start clears the error; a start pulse during ISSUE is ignored
    mask = {$urandom, $urandom} | 64'h1;
    applyStimulus(PLAIN ^ mask, mask, 1'b1, -1, 5, fd, dc, se, ead, eas);
    checkOutput("pulse_err_cleared", {63'd0, eas}, 64'd0);
    checkOutput("pulse_done_count", 64'(dc), 64'd1);
    checkOutput("pulse_done_cycle", 64'(fd), 64'd21);
    checkOutput("pulse_sequence", 64'(se), 64'd0);
    checkOutput("pulse_recomb", bus.state_out_s0 ^ bus.state_out_s1, CIPH);

    // Start held high: back-to-back jobs every 23 cycles
    @(negedge clk);
    bus.state_in_s0 = PLAIN;
    bus.state_in_s1 = 64'd0;
    bus.rnd_data    = 4'h0;
    bus.rnd_valid   = 1'b1;
    bus.start       = 1'b1;
    d1 = -1; d2 = -1; cnt = 0;
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cnt++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checkOutput("b2b_first_done", 64'(d1), 64'd21);
    checkOutput("b2b_second_done", 64'(d2), 64'd44);
    checkOutput("b2b_done_count", 64'(cnt), 64'd2);
    checkOutput("b2b_third_done", {63'd0, seen}, 64'd1);
    checkOutput("b2b_out0", bus.state_out_s0, CIPH);

    // Reset in the middle of ISSUE
    @(negedge clk);
    bus.start    = 1'b1;
    bus.rnd_data = 4'hA;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      bus.start     = 1'b0;
      bus.rnd_valid = (c != 2);
    end
    checkOutput("pre_reset_err", {63'd0, bus.rnd_err}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy",  {63'd0, bus.busy}, 64'd0);
    checkOutput("midrst_ready", {63'd0, bus.rnd_ready}, 64'd0);
    checkOutput("midrst_err",   {63'd0, bus.rnd_err}, 64'd0);
    checkOutput("midrst_x",     {56'd0, bus.sbox_x_s0, bus.sbox_x_s1}, 64'd0);
    checkOutput("midrst_fresh", {60'd0, bus.sbox_fresh}, 64'd0);
    checkOutput("midrst_out0",  bus.state_out_s0, 64'd0);
    checkOutput("midrst_out1",  bus.state_out_s1, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    forceY = 1'b1;
    writes = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((bus.state_out_s0 | bus.state_out_s1) !== 64'd0) writes++;
      if (bus.busy !== 1'b0) writes++;
    end
    checkOutput("postrst_no_writes", 64'(writes), 64'd0);
    forceY = 1'b0;

    // First job after reset behaves normally
    mask = {$urandom, $urandom} | 64'h1;
    applyStimulus(PLAIN ^ mask, mask, 1'b1, -1, -1, fd, dc, se, ead, eas);
    checkOutput("after_rst_recomb", bus.state_out_s0 ^ bus.state_out_s1, CIPH);
    checkOutput("after_rst_done_cycle", 64'(fd), 64'd21);
    checkOutput("after_rst_sequence", 64'(se), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
